mix_columns_seq: RTL

//  Column-serial (Inv)MixColumns engine for the AES datapath.
//  - Latches a 128-bit state.
//  - Transforms one 32-bit column per cycle over 4 cycles.
//  - Presents each result as (col_num, col_out, col_valid) to the downstream column-insert stage.
//  - Also accumulates the full transformed state internally for direct use.

---
 rtl/mix_columns_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// Column-serial (Inv)MixColumns engine: latches a 128-bit AES state and transforms one
// 32-bit column per cycle, streaming each column out and accumulating the full result.
module mix_columns_seq #(
    parameter bit INVERSE = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         col_valid,
    output logic [1:0]   col_num,
    output logic [31:0]  col_out,
    output logic [127:0] state_out,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         r_fsm;
    state_e         w_fsm_next;
    logic [1:0]     r_cnt;
    logic [127:0]   r_data;
    logic [127:0]   r_state_out;
    logic [31:0]    w_col_in;
    logic [31:0]    w_col_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] p;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        p  = 8'h00;
        case (c)
            8'h01:   p = b;
            8'h02:   p = x2;
            8'h03:   p = x2 ^ b;
            8'h09:   p = x8 ^ b;
            8'h0b:   p = x8 ^ x2 ^ b;
            8'h0d:   p = x8 ^ x4 ^ b;
            8'h0e:   p = x8 ^ x4 ^ x2;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    // Row r applies the coefficient vector rotated right by r: a_j uses coef[(j - r) mod 4].
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a    [4];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [1:0] idx;
        logic [31:0] res;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        if (INVERSE) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - r);
                acc = acc ^ gf_mul(a[j], coef[idx]);
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    always_comb begin
        w_col_in = r_data[127:96];
        unique case (r_cnt)
            2'd0: w_col_in = r_data[127:96];
            2'd1: w_col_in = r_data[95:64];
            2'd2: w_col_in = r_data[63:32];
            2'd3: w_col_in = r_data[31:0];
            default: w_col_in = r_data[127:96];
        endcase
    end

    assign w_col_res = mix_col(w_col_in);

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            StIdle:  if (start) w_fsm_next = StRun;
            StRun:   if (r_cnt == 2'd3) w_fsm_next = StDone;
            StDone:  w_fsm_next = StIdle;
            default: w_fsm_next = StIdle;
        endcase
    end

    always_comb begin
        busy      = (r_fsm != StIdle);
        col_valid = (r_fsm == StRun);
        col_num   = col_valid ? r_cnt : 2'd0;
        col_out   = col_valid ? w_col_res : 32'h0;
        done      = (r_fsm == StDone);
        state_out = r_state_out;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fsm       <= StIdle;
            r_cnt       <= 2'd0;
            r_data      <= 128'h0;
            r_state_out <= 128'h0;
        end else begin
            r_fsm <= w_fsm_next;
            case (r_fsm)
                StIdle: begin
                    if (start) begin
                        r_data <= state_in;
                        r_cnt  <= 2'd0;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 2'd1;
                    unique case (r_cnt)
                        2'd0: r_state_out[127:96] <= w_col_res;
                        2'd1: r_state_out[95:64]  <= w_col_res;
                        2'd2: r_state_out[63:32]  <= w_col_res;
                        2'd3: r_state_out[31:0]   <= w_col_res;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
